// File: rtl/tail_light_pkg.sv
// Shared definitions for the Thunderbird tail-light sequencer: one-hot state
// codes, the state enum built from them, the 3-bit lamp patterns and a helper
// that turns a state into the six lamp outputs.
package tail_light_pkg;

  // One-hot state codes; exactly one bit set per state.
  localparam logic [7:0] ST_IDLE = 8'b0000_0001;
  localparam logic [7:0] ST_L1   = 8'b0000_0010;
  localparam logic [7:0] ST_L2   = 8'b0000_0100;
  localparam logic [7:0] ST_L3   = 8'b0000_1000;
  localparam logic [7:0] ST_R1   = 8'b0001_0000;
  localparam logic [7:0] ST_R2   = 8'b0010_0000;
  localparam logic [7:0] ST_R3   = 8'b0100_0000;
  localparam logic [7:0] ST_LR3  = 8'b1000_0000;

  typedef enum logic [7:0] {
    IDLE = ST_IDLE,
    L1   = ST_L1,
    L2   = ST_L2,
    L3   = ST_L3,
    R1   = ST_R1,
    R2   = ST_R2,
    R3   = ST_R3,
    LR3  = ST_LR3
  } state_t;

  // Lamp patterns written innermost-lamp-first in bit 0, i.e. the left-side
  // ordering {lc,lb,la}. The right side is the mirror image of these.
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_P1  = 3'b001;
  localparam logic [2:0] LAMP_P2  = 3'b011;
  localparam logic [2:0] LAMP_P3  = 3'b111;

  // Right lamps are ordered {ra,rb,rc} with ra innermost, so the inner lamp
  // sits in the MSB; mirroring a left pattern gives the right pattern.
  function automatic logic [2:0] mirror3(input logic [2:0] p);
    return {p[0], p[1], p[2]};
  endfunction

  // Returns {l_lamps, r_lamps} for a given state.
  function automatic logic [5:0] lampPattern(input state_t s);
    logic [5:0] pat;
    pat = {LAMP_OFF, LAMP_OFF};
    case (s)
      IDLE:    pat = {LAMP_OFF, LAMP_OFF};
      L1:      pat = {LAMP_P1, LAMP_OFF};
      L2:      pat = {LAMP_P2, LAMP_OFF};
      L3:      pat = {LAMP_P3, LAMP_OFF};
      R1:      pat = {LAMP_OFF, mirror3(LAMP_P1)};
      R2:      pat = {LAMP_OFF, mirror3(LAMP_P2)};
      R3:      pat = {LAMP_OFF, mirror3(LAMP_P3)};
      LR3:     pat = {LAMP_P3, LAMP_P3};
      default: pat = {LAMP_OFF, LAMP_OFF};
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/tail_light_fsm_if.sv
// Bundle of the sequencer's switch, tick, timer-control and lamp signals.
// The master side is whoever owns the switches and the timer tick (the
// vehicle/bench); the slave side is the sequencer itself.
interface tail_light_fsm_if;
  logic       left;
  logic       right;
  logic       haz;
  logic       enable;
  logic       timer_clear;
  logic [2:0] l_lamps;
  logic [2:0] r_lamps;

  modport master (
    output left,
    output right,
    output haz,
    output enable,
    input  timer_clear,
    input  l_lamps,
    input  r_lamps
  );

  modport slave (
    input  left,
    input  right,
    input  haz,
    input  enable,
    output timer_clear,
    output l_lamps,
    output r_lamps
  );
endinterface

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for one asynchronous switch input. STAGES must be
// at least 2; the output is the last flop of the chain. All flops clear on
// the synchronous reset so the FSM sees a released switch after reset.
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the flop chain, bit 0 being the first stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tail_light_fsm.sv
// Thunderbird tail-light sequencer. Synchronises the three switches, steps
// the lamp sequence once per timer tick and holds the timer in clear while
// idle, so the first lit state always lasts one full timer period. Lamps and
// timer_clear are registered from the next state to keep them glitch-free.
module tail_light_fsm
  import tail_light_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  tail_light_fsm_if.slave   bus
);

  logic   leftSync;
  logic   rightSync;
  logic   hazSync;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] lamps_d;
  logic [2:0] lLamps_q;
  logic [2:0] rLamps_q;
  logic       timerClear_q;

  sync_2ff #(.STAGES(SYNC_STAGES)) uSyncLeft (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.left),
    .q_o   (leftSync)
  );

  sync_2ff #(.STAGES(SYNC_STAGES)) uSyncRight (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.right),
    .q_o   (rightSync)
  );

  sync_2ff #(.STAGES(SYNC_STAGES)) uSyncHaz (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.haz),
    .q_o   (hazSync)
  );

  // Next-state decision: IDLE reacts at once, lit states move only on a tick,
  // and a hazard seen during the first two steps jumps straight to LR3.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hazSync || (leftSync && rightSync)) begin
          state_d = LR3;
        end else if (leftSync) begin
          state_d = L1;
        end else if (rightSync) begin
          state_d = R1;
        end
      end
      L1: begin
        if (bus.enable) begin
          state_d = hazSync ? LR3 : L2;
        end
      end
      L2: begin
        if (bus.enable) begin
          state_d = hazSync ? LR3 : L3;
        end
      end
      L3: begin
        if (bus.enable) begin
          state_d = IDLE;
        end
      end
      R1: begin
        if (bus.enable) begin
          state_d = hazSync ? LR3 : R2;
        end
      end
      R2: begin
        if (bus.enable) begin
          state_d = hazSync ? LR3 : R3;
        end
      end
      R3: begin
        if (bus.enable) begin
          state_d = IDLE;
        end
      end
      LR3: begin
        if (bus.enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decode the lamp pattern of the state about to be entered.
  always_comb begin
    lamps_d = lampPattern(state_d);
  end

  // State and outputs registered together; reset overrides any tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lLamps_q     <= LAMP_OFF;
      rLamps_q     <= LAMP_OFF;
      timerClear_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lLamps_q     <= lamps_d[5:3];
      rLamps_q     <= lamps_d[2:0];
      timerClear_q <= (state_d == IDLE);
    end
  end

  assign bus.l_lamps     = lLamps_q;
  assign bus.r_lamps     = rLamps_q;
  assign bus.timer_clear = timerClear_q;

endmodule

// File: tb/tb_tail_light_fsm.sv
// Self-checking bench for the tail-light sequencer: directed scenarios with
// literal expectations plus a randomized run, all cross-checked every cycle
// against a behavioural model of the lamp sequence.
module tb_tail_light_fsm;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cycleCnt;
  bit   randEn;

  tail_light_fsm_if bus ();

  tail_light_fsm #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, first rising edge at 5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 left sweep, 2 right sweep, 3 hazard;
  // step counts lit lamps on the active side. Switches see a 2-edge delay.
  bit [1:0] sL, sR, sH;
  int       mMode;
  int       mStep;
  bit       modelValid;

  always @(posedge clk) begin
    bit ls, rs, hs;
    ls = sL[1];
    rs = sR[1];
    hs = sH[1];
    if (reset) begin
      sL = 2'b00; sR = 2'b00; sH = 2'b00;
      mMode = 0; mStep = 0;
      modelValid = 1'b1;
    end else begin
      if (mMode == 0) begin
        if (hs || (ls && rs)) begin
          mMode = 3;
        end else if (ls) begin
          mMode = 1; mStep = 1;
        end else if (rs) begin
          mMode = 2; mStep = 1;
        end
      end else if (bus.enable) begin
        if (mMode == 3 || mStep == 3) begin
          mMode = 0; mStep = 0;
        end else if (hs) begin
          mMode = 3;
        end else begin
          mStep = mStep + 1;
        end
      end
      sL = {sL[0], bus.left};
      sR = {sR[0], bus.right};
      sH = {sH[0], bus.haz};
    end
  end

  function automatic logic [2:0] modelL();
    int v;
    v = (mMode == 3) ? 7 : (mMode == 1) ? ((1 << mStep) - 1) : 0;
    return v[2:0];
  endfunction

  function automatic logic [2:0] modelR();
    int v;
    v = (mMode == 3) ? 7 : (mMode == 2) ? ((7 << (3 - mStep)) & 7) : 0;
    return v[2:0];
  endfunction

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checks++;
      if (bus.l_lamps !== modelL() || bus.r_lamps !== modelR() ||
          bus.timer_clear !== (mMode == 0)) begin
        errors++;
        $display("[TB] FAIL model t=%0t: got l=%b r=%b clr=%b, expected l=%b r=%b clr=%b",
                 $time, bus.l_lamps, bus.r_lamps, bus.timer_clear,
                 modelL(), modelR(), (mMode == 0));
      end
    end
  end

  // Advance to the next falling edge and drive the tick for the coming cycle.
  task automatic stepCycle();
    @(negedge clk);
    cycleCnt++;
    if (randEn) bus.enable = ($urandom_range(0, 3) == 0);
    else        bus.enable = (cycleCnt % 4 == 0);
  endtask

  task automatic applyStimulus(input bit l, input bit r, input bit h);
    bus.left  = l;
    bus.right = r;
    bus.haz   = h;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expL,
                             input logic [2:0] expR, input logic expClr);
    checks++;
    if (bus.l_lamps !== expL || bus.r_lamps !== expR || bus.timer_clear !== expClr) begin
      errors++;
      $display("[TB] FAIL %s: got l=%b r=%b clr=%b, expected l=%b r=%b clr=%b",
               name, bus.l_lamps, bus.r_lamps, bus.timer_clear, expL, expR, expClr);
    end
  endtask

  // Step until any output changes, bounded by budget cycles.
  task automatic waitChange(input string name, input int budget);
    logic [6:0] prev;
    bit found;
    found = 1'b0;
    prev = {bus.l_lamps, bus.r_lamps, bus.timer_clear};
    for (int i = 0; i < budget && !found; i++) begin
      stepCycle();
      if ({bus.l_lamps, bus.r_lamps, bus.timer_clear} !== prev) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no output change within %0d cycles, outputs l=%b r=%b clr=%b",
               name, budget, bus.l_lamps, bus.r_lamps, bus.timer_clear);
    end
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("reset", 3'b000, 3'b000, 1'b1);
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cycleCnt = 0; randEn = 1'b0;
    modelValid = 1'b0; mMode = 0; mStep = 0;
    sL = 2'b00; sR = 2'b00; sH = 2'b00;
    bus.enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // 1: reset, then ticks while idle change nothing
    applyReset();
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      checkOutput("idle_ticks", 3'b000, 3'b000, 1'b1);
    end

    // 2: left held, full sweep and one-cycle idle gap before repeating
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitChange("left_l1", 6);  checkOutput("left_l1", 3'b001, 3'b000, 1'b0);
    waitChange("left_l2", 8);  checkOutput("left_l2", 3'b011, 3'b000, 1'b0);
    waitChange("left_l3", 8);  checkOutput("left_l3", 3'b111, 3'b000, 1'b0);
    waitChange("left_idle", 8); checkOutput("left_idle", 3'b000, 3'b000, 1'b1);
    stepCycle();               checkOutput("left_repeat", 3'b001, 3'b000, 1'b0);
    applyReset();

    // 3: one-cycle right pulse runs the whole right sweep once
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitChange("right_r1", 6);  checkOutput("right_r1", 3'b000, 3'b100, 1'b0);
    waitChange("right_r2", 8);  checkOutput("right_r2", 3'b000, 3'b110, 1'b0);
    waitChange("right_r3", 8);  checkOutput("right_r3", 3'b000, 3'b111, 1'b0);
    waitChange("right_idle", 8); checkOutput("right_idle", 3'b000, 3'b000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("right_stays_off", 3'b000, 3'b000, 1'b1);
    end
    applyReset();

    // 4: hazard during L2 aborts to LR3, then idle
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitChange("haz_l1", 6);  checkOutput("haz_l1", 3'b001, 3'b000, 1'b0);
    waitChange("haz_l2", 8);  checkOutput("haz_l2", 3'b011, 3'b000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitChange("haz_lr3", 8); checkOutput("haz_lr3", 3'b111, 3'b111, 1'b0);
    waitChange("haz_idle", 8); checkOutput("haz_idle", 3'b000, 3'b000, 1'b1);
    applyReset();

    // 5: left and right together go straight to LR3
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitChange("both_lr3", 6); checkOutput("both_lr3", 3'b111, 3'b111, 1'b0);
    waitChange("both_idle", 8); checkOutput("both_idle", 3'b000, 3'b000, 1'b1);
    applyReset();

    // 6: reset arriving with a tick while in R2
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitChange("rst_r1", 6); checkOutput("rst_r1", 3'b000, 3'b100, 1'b0);
    waitChange("rst_r2", 8); checkOutput("rst_r2", 3'b000, 3'b110, 1'b0);
    for (int i = 0; i < 8 && bus.enable !== 1'b1; i++) stepCycle();
    checkOutput("rst_pre", 3'b000, 3'b110, 1'b0);
    reset = 1'b1;
    stepCycle();
    checkOutput("rst_in_r2", 3'b000, 3'b000, 1'b1);
    reset = 1'b0;
    applyReset();

    // Randomized run, checked by the model only
    randEn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stepCycle();
      if ($urandom_range(0, 7) == 0)  bus.left  = ~bus.left;
      if ($urandom_range(0, 7) == 0)  bus.right = ~bus.right;
      if ($urandom_range(0, 15) == 0) bus.haz   = ~bus.haz;
      reset = ($urandom_range(0, 99) == 0);
    end
    reset = 1'b0;
    stepCycle();
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
